// File: rtl/sdrd_rgbpack_if.sv
// Byte-stream input and frame-buffer write port of the BMP pixel packer.
// The packer sits on the slave side; the byte source / frame buffer on the master side.
interface sdrd_rgbpack_if #(
    parameter int ADR_W = 17
);
    logic             START;
    logic             RGBWR;
    logic [7:0]       RGBDATA;
    logic             BUSY;
    logic             FB_WE;
    logic [ADR_W-1:0] FB_ADR;
    logic [15:0]      FB_DATA;
    logic             DONE;

    modport master (
        output START, RGBWR, RGBDATA,
        input  BUSY, FB_WE, FB_ADR, FB_DATA, DONE
    );

    modport slave (
        input  START, RGBWR, RGBDATA,
        output BUSY, FB_WE, FB_ADR, FB_DATA, DONE
    );
endinterface

// File: rtl/sdrd_rgbpack.sv
// BMP byte stream to RGB565 frame-buffer writer: skips the header, packs B,G,R
// triplets, drops row padding and flips the bottom-up row order to top-down.
module sdrd_rgbpack #(
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int HDR_BYTES = 54,
    parameter int ADR_W     = 17
) (
    input  logic          CLK,
    input  logic          RST_X,
    sdrd_rgbpack_if.slave bus
);

    localparam int PAD_N = (4 - ((WIDTH * 3) % 4)) % 4;
    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);
    localparam int HDR_W = (HDR_BYTES > 0) ? $clog2(HDR_BYTES + 1) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [HDR_W-1:0] HDR_LAST = (HDR_BYTES > 0) ? HDR_W'(HDR_BYTES - 1) : '0;
    localparam logic [1:0]       PAD_LAST = (PAD_N > 0) ? 2'(PAD_N - 1) : 2'd0;
    localparam logic [ADR_W-1:0] BASE_TOP = ADR_W'((HEIGHT - 1) * WIDTH);
    localparam logic [ADR_W-1:0] ROW_STEP = ADR_W'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PIX,
        S_PAD,
        S_FIN
    } state_t;

    state_t           state, state_nxt;
    logic [HDR_W-1:0] hdr_cnt, hdr_cnt_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [1:0]       pad_cnt, pad_cnt_nxt;
    logic [1:0]       lane, lane_nxt;
    logic [ADR_W-1:0] row_base, row_base_nxt;
    logic [7:0]       b_p0, b_p0_nxt;
    logic [7:0]       g_p0, g_p0_nxt;
    logic             vld_p1, vld_p1_nxt;
    logic [ADR_W-1:0] adr_p1, adr_p1_nxt;
    logic [15:0]      data_p1, data_p1_nxt;
    logic             busy, busy_nxt;
    logic             done_p1, done_p1_nxt;
    logic             row_step;

    function automatic logic [15:0] to_rgb565(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    always_comb begin
        state_nxt    = state;
        hdr_cnt_nxt  = hdr_cnt;
        col_nxt      = col;
        row_nxt      = row;
        pad_cnt_nxt  = pad_cnt;
        lane_nxt     = lane;
        row_base_nxt = row_base;
        b_p0_nxt     = b_p0;
        g_p0_nxt     = g_p0;
        vld_p1_nxt   = 1'b0;
        adr_p1_nxt   = adr_p1;
        data_p1_nxt  = data_p1;
        busy_nxt     = busy;
        done_p1_nxt  = 1'b0;
        row_step     = 1'b0;

        // START aborts anything in flight and swallows a coincident byte
        if (bus.START) begin
            state_nxt    = (HDR_BYTES == 0) ? S_PIX : S_HDR;
            hdr_cnt_nxt  = '0;
            col_nxt      = '0;
            row_nxt      = '0;
            pad_cnt_nxt  = '0;
            lane_nxt     = '0;
            row_base_nxt = BASE_TOP;
            busy_nxt     = 1'b1;
        end else begin
            case (state)
                S_IDLE: ;
                S_HDR: begin
                    if (bus.RGBWR) begin
                        hdr_cnt_nxt = hdr_cnt + 1'b1;
                        if (hdr_cnt == HDR_LAST) state_nxt = S_PIX;
                    end
                end
                S_PIX: begin
                    if (bus.RGBWR) begin
                        case (lane)
                            2'd0: begin
                                b_p0_nxt = bus.RGBDATA;
                                lane_nxt = 2'd1;
                            end
                            2'd1: begin
                                g_p0_nxt = bus.RGBDATA;
                                lane_nxt = 2'd2;
                            end
                            default: begin
                                vld_p1_nxt  = 1'b1;
                                adr_p1_nxt  = row_base + ADR_W'(col);
                                data_p1_nxt = to_rgb565(bus.RGBDATA, g_p0, b_p0);
                                lane_nxt    = 2'd0;
                                if (col == COL_LAST) begin
                                    col_nxt = '0;
                                    if (PAD_N != 0) begin
                                        state_nxt   = S_PAD;
                                        pad_cnt_nxt = '0;
                                    end else begin
                                        row_step = 1'b1;
                                    end
                                end else begin
                                    col_nxt = col + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_PAD: begin
                    if (bus.RGBWR) begin
                        if (pad_cnt == PAD_LAST) row_step = 1'b1;
                        else                     pad_cnt_nxt = pad_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    state_nxt   = S_IDLE;
                    done_p1_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                end
                default: state_nxt = S_IDLE;
            endcase

            // Rows arrive bottom-up, so the write base walks down one row at a time
            if (row_step) begin
                if (row == ROW_LAST) begin
                    state_nxt = S_FIN;
                end else begin
                    row_nxt      = row + 1'b1;
                    row_base_nxt = row_base - ROW_STEP;
                    state_nxt    = S_PIX;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state    <= S_IDLE;
            hdr_cnt  <= '0;
            col      <= '0;
            row      <= '0;
            pad_cnt  <= '0;
            lane     <= '0;
            row_base <= '0;
            b_p0     <= '0;
            g_p0     <= '0;
            vld_p1   <= 1'b0;
            adr_p1   <= '0;
            data_p1  <= '0;
            busy     <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hdr_cnt  <= hdr_cnt_nxt;
            col      <= col_nxt;
            row      <= row_nxt;
            pad_cnt  <= pad_cnt_nxt;
            lane     <= lane_nxt;
            row_base <= row_base_nxt;
            b_p0     <= b_p0_nxt;
            g_p0     <= g_p0_nxt;
            vld_p1   <= vld_p1_nxt;
            adr_p1   <= adr_p1_nxt;
            data_p1  <= data_p1_nxt;
            busy     <= busy_nxt;
            done_p1  <= done_p1_nxt;
        end
    end

    assign bus.BUSY    = busy;
    assign bus.FB_WE   = vld_p1;
    assign bus.FB_ADR  = adr_p1;
    assign bus.FB_DATA = data_p1;
    assign bus.DONE    = done_p1;

endmodule

// File: doc/sdrd_rgbpack.md
# sdrd_rgbpack

Pixel packer downstream of `sdrd_SPIctrl`. It consumes the byte stream on `SPIOUT_RGBWR`/`SPIOUT_RGBDATA` while a BMP image file is being read. It discards the BMP header, assembles B,G,R byte triplets into RGB565 pixels, and drops the row padding. It writes each pixel to the frame buffer at a top-down address, because BMP rows are stored bottom-up.

## Interface

Parameters:
- `WIDTH`, 320, image width in pixels.
- `HEIGHT`, 240, image height in pixels.
- `HDR_BYTES`, 54, number of header bytes discarded before pixel data.
- `ADR_W`, 17, frame-buffer address width; must satisfy 2^ADR_W ≥ WIDTH*HEIGHT.

Ports:
- `CLK` in 1: single system clock.
- `RST_X` in 1: reset, synchronous, active-low.
- `START` in 1: one-cycle pulse that arms the block for a new image.
- `RGBWR` in 1: byte valid strobe from `SPIOUT_RGBWR`.
- `RGBDATA` in 8: byte from `SPIOUT_RGBDATA`; valid only when `RGBWR`=1.
- `BUSY` out 1: high from `START` until `DONE`.
- `FB_WE` out 1: frame-buffer write strobe, one cycle per pixel.
- `FB_ADR` out ADR_W: frame-buffer word address.
- `FB_DATA` out 16: RGB565 pixel.
- `DONE` out 1: one-cycle pulse after the last pixel write.

## Operation

- **Derived constants:**
  - PAD = (4 − (WIDTH*3) mod 4) mod 4.
  - Row byte count = WIDTH*3 + PAD.
- **States:** IDLE, HDR, PIX, PAD, FIN.
- **IDLE:**
  - `RGBWR` is ignored.
  - `START` → HDR; byte counter=0, col=0, row=0, lane=0.
- **HDR:**
  - Each `RGBWR` increments the byte counter.
  - The byte that makes the count HDR_BYTES moves the state to PIX.
  - If HDR_BYTES=0, `START` goes directly to PIX.
- **PIX:**
  - `RGBWR` bytes arrive in lane order 0=B, 1=G, 2=R.
  - B and G are held in registers.
  - When the R byte arrives, the block emits a pixel:
    - `FB_DATA` = {R[7:3], G[7:2], B[7:3]}.
    - `FB_ADR` = (HEIGHT−1−row)*WIDTH + col.
  - Then col increments.
  - When col reaches WIDTH, col resets to 0 and the state moves to PAD, or to the next-row logic directly if PAD=0.
- **PAD:**
  - Discards PAD bytes.
  - Then row increments, and the state returns to PIX.
- **Row wrap:**
  - The next-row step after row HEIGHT−1 moves the state to FIN instead of PIX.
  - This step occurs after the padding of the last row.
- **FIN:**
  - `DONE`=1 for one cycle.
  - Then IDLE.
  - Any bytes after the last pixel or padding are ignored.
- **Restart:**
  - `START` in any non-IDLE state aborts the current image.
  - It re-enters HDR with all counters cleared, in the same cycle.
  - No pending pixel is written.
- **`START` coincident with `RGBWR`:** the byte is discarded, because `START` wins.
- **Arithmetic:**
  - The address product is computed with an incremental row base (row base −= WIDTH per row, starting at (HEIGHT−1)*WIDTH); no multiplier.
  - All counters are sized to their maximum and never wrap.

## Timing

- **Reset (`RST_X`=0 at a rising edge):**
  - State=IDLE.
  - `BUSY`=0, `FB_WE`=0, `FB_ADR`=0, `FB_DATA`=0, `DONE`=0.
  - All counters and lanes =0.
  - Reset mid-image drops the image silently.
- **`BUSY`:**
  - Rises on the edge that samples `START`.
  - Falls on the same edge that raises `DONE`.
- **Throughput:** one byte per cycle maximum; back-to-back `RGBWR` at every cycle is supported with no stall. The block has no back-pressure output.
- **Pixel latency:** `FB_WE`, `FB_ADR` and `FB_DATA` are registered. They are valid in the cycle after the edge that samples the R byte, and `FB_WE` is high for exactly one cycle.
- **`FB_ADR`/`FB_DATA` hold:** they keep their last value when `FB_WE`=0.
- **`DONE` latency:** `DONE` is asserted one cycle after the edge that samples the final byte (last R byte or last pad byte). It is never in the same cycle as the last `FB_WE`; `DONE` follows it by one cycle.

## Test plan

- **Reset values:** Hold `RST_X`=0 for 3 cycles with `RGBWR` toggling → all outputs 0, `BUSY`=0; no `FB_WE` in IDLE.
- **Small image, no padding:** WIDTH=4, HEIGHT=2, HDR_BYTES=54. `START`, then 54 header bytes and 24 pixel bytes back-to-back, first B=0xF8, G=0xFC, R=0xF8 → 8 `FB_WE` pulses.
  - Addresses in order: 4,5,6,7,0,1,2,3.
  - First `FB_DATA`=0xFFFF.
  - `DONE` one cycle after the last write; `BUSY` low afterwards.
- **Padding:** WIDTH=3, HEIGHT=2 (PAD=3). Pixel bytes B=0x08, G=0x04, R=0x10 → `FB_DATA`=0x1021. The 3 pad bytes per row produce no `FB_WE`. Addresses in order: 3,4,5,0,1,2.
- **Gapped stream:** same as the small-image scenario with `RGBWR` asserted every 3rd cycle → identical write sequence and data.
- **Abort:** pulse `START` again after 2 pixels have been written → counters restart. The next 54 bytes are treated as header, and the first new pixel goes to address (HEIGHT−1)*WIDTH.
- **Trailing bytes and simultaneous `START`:**
  - 5 extra bytes after `DONE` → no `FB_WE`.
  - `START` and `RGBWR` asserted in the same cycle → that byte is not counted in the header.
